// File: rtl/power3_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | power3_pkg                                                               |
// | Shared state encoding, base constant and default widths for the          |
// | power-of-3 stream checker.                                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package power3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int POW_BASE          = 3;
    localparam int DEFAULT_DATA_SIZE = 8;
    localparam int DEFAULT_CNT_WIDTH = 16;

endpackage : power3_pkg
`default_nettype wire

// File: rtl/power3_expect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | power3_expect                                                            |
// | Expected-value register: loads 1 on start, multiplies by POW_BASE        |
// | (mod 2^data_size) on every accepted beat.                                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module power3_expect
    import power3_pkg::*;
#(
    parameter int data_size = DEFAULT_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 accept_i,
    output logic [data_size-1:0] expected_o
);

    localparam logic [data_size-1:0] c_base = data_size'(POW_BASE);
    localparam logic [data_size-1:0] c_one  = data_size'(1);

    logic [data_size-1:0] expected_q;
    logic [data_size-1:0] expected_d;

    // Truncating product gives the intended modulo-2^data_size wrap.
    always_comb begin
        expected_d = expected_q;
        if (start_i) begin
            expected_d = c_one;
        end else if (accept_i) begin
            expected_d = expected_q * c_base;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expected_q <= c_one;
        end else begin
            expected_q <= expected_d;
        end
    end

    assign expected_o = expected_q;

endmodule : power3_expect
`default_nettype wire

// File: rtl/power3_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | power3_checker                                                           |
// | Stream sink that checks beats against successive powers of 3, counts     |
// | matches/errors and captures the first mismatch.                          |
// | Optional macro POWER3_CHK_THROTTLE_EN inserts a one-cycle ready bubble   |
// | after every accepted beat.                                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module power3_checker
    import power3_pkg::*;
#(
    parameter int data_size = DEFAULT_DATA_SIZE,
    parameter int cnt_width = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [data_size-1:0] s_data,
    input  logic                 s_last,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [cnt_width-1:0] match_count,
    output logic [cnt_width-1:0] error_count,
    output logic [cnt_width-1:0] err_index,
    output logic [data_size-1:0] err_data,
    output logic                 err_flag
);

    localparam logic [cnt_width-1:0] c_cnt_max = '1;
    localparam logic [cnt_width-1:0] c_cnt_one = cnt_width'(1);

    state_t               state_q;
    state_t               state_d;
    logic [cnt_width-1:0] match_q;
    logic [cnt_width-1:0] error_q;
    logic [cnt_width-1:0] beat_idx_q;
    logic [cnt_width-1:0] err_index_q;
    logic [data_size-1:0] err_data_q;
    logic                 err_flag_q;
    logic [data_size-1:0] w_expected;
    logic                 w_accept;
    logic                 w_match;
    logic                 w_hold;

`ifdef POWER3_CHK_THROTTLE_EN
    logic bubble_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_q <= 1'b0;
        end else if (start) begin
            bubble_q <= 1'b0;
        end else begin
            bubble_q <= w_accept;
        end
    end

    assign w_hold = bubble_q;
`else
    assign w_hold = 1'b0;
`endif

    assign w_accept = s_valid && s_ready;
    assign w_match  = (s_data == w_expected);

    power3_expect #(
        .data_size (data_size)
    ) u_expect (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .accept_i   (w_accept),
        .expected_o (w_expected)
    );

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_RUN: begin
                busy    = 1'b1;
                s_ready = !start && !w_hold;
                if (w_accept && s_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
        // start re-arms from any state and blocks acceptance in the same cycle
        if (start) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q     <= '0;
            error_q     <= '0;
            beat_idx_q  <= '0;
            err_index_q <= '0;
            err_data_q  <= '0;
            err_flag_q  <= 1'b0;
        end else if (start) begin
            match_q     <= '0;
            error_q     <= '0;
            beat_idx_q  <= '0;
            err_index_q <= '0;
            err_data_q  <= '0;
            err_flag_q  <= 1'b0;
        end else if (w_accept) begin
            if (beat_idx_q != c_cnt_max) begin
                beat_idx_q <= beat_idx_q + c_cnt_one;
            end
            if (w_match) begin
                if (match_q != c_cnt_max) begin
                    match_q <= match_q + c_cnt_one;
                end
            end else begin
                if (error_q != c_cnt_max) begin
                    error_q <= error_q + c_cnt_one;
                end
                if (!err_flag_q) begin
                    err_flag_q  <= 1'b1;
                    err_index_q <= beat_idx_q;
                    err_data_q  <= s_data;
                end
            end
        end
    end

    assign match_count = match_q;
    assign error_count = error_q;
    assign err_index   = err_index_q;
    assign err_data    = err_data_q;
    assign err_flag    = err_flag_q;
    assign pass        = done && (error_q == '0) && (match_q != '0);

endmodule : power3_checker
`default_nettype wire

// File: tb/tb_power3_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_power3_checker                                                        |
// | Scoreboard bench for power3_checker (16-bit and 4-bit counter builds).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_power3_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;

    logic        s_ready, busy, done, pass, err_flag;
    logic [15:0] match_count, error_count, err_index;
    logic [7:0]  err_data;

    logic        s_ready4, busy4, done4, pass4, err_flag4;
    logic [3:0]  match_count4, error_count4, err_index4;
    logic [7:0]  err_data4;

    always #5 clk = ~clk;

    power3_checker #(.data_size(8), .cnt_width(16)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .busy(busy), .done(done), .pass(pass),
        .match_count(match_count), .error_count(error_count), .err_index(err_index),
        .err_data(err_data), .err_flag(err_flag)
    );

    power3_checker #(.data_size(8), .cnt_width(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready4),
        .s_data(s_data), .s_last(s_last), .busy(busy4), .done(done4), .pass(pass4),
        .match_count(match_count4), .error_count(error_count4), .err_index(err_index4),
        .err_data(err_data4), .err_flag(err_flag4)
    );

    typedef struct {
        logic [15:0] m;
        logic [15:0] e;
        logic        f;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    int   m_exp, m_match, m_err, m_idx, m_eidx, m_edata;
    bit   m_flag, m_done, prev_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_exp = 1; m_match = 0; m_err = 0; m_idx = 0; m_eidx = 0; m_edata = 0;
        m_flag = 0; m_done = 0; prev_acc = 0;
        sb.delete();
    endtask

    function automatic int pow3(input int n);
        int v = 1;
        for (int i = 0; i < n; i++) v = (v * 3) % 256;
        return v;
    endfunction

    // Called at a negedge; returns at the next negedge.
    task automatic cycle_beat(input bit v, input logic [7:0] d, input bit l, output bit acc);
        exp_t e;
        s_valid = v; s_data = d; s_last = l;
        #1;
        acc = v && s_ready;
`ifdef POWER3_CHK_THROTTLE_EN
        if (prev_acc) check("bubble_ready", s_ready, 0);
`endif
        if (acc) begin
            if (int'(d) == m_exp) m_match++;
            else begin
                m_err++;
                if (!m_flag) begin m_flag = 1; m_eidx = m_idx; m_edata = d; end
            end
            m_exp = (m_exp * 3) % 256;
            m_idx++;
            if (l) m_done = 1;
            e.m = 16'(m_match); e.e = 16'(m_err); e.f = m_flag;
            sb.push_back(e);
        end
        prev_acc = acc;
        @(posedge clk); #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("match_count", match_count, e.m);
            check("error_count", error_count, e.e);
            check("err_flag", err_flag, e.f);
        end
        @(negedge clk);
    endtask

    task automatic send_beat(input logic [7:0] d, input bit l);
        bit acc = 0;
        for (int t = 0; t < 8 && !acc; t++) cycle_beat(1, d, l, acc);
        if (!acc) check("handshake_timeout", 0, 1);
        s_valid = 0; s_last = 0;
    endtask

    task automatic do_start();
        start = 1; s_valid = 0; s_last = 0;
        @(posedge clk); #1;
        start = 0;
        model_reset();
        check("busy_after_start", busy, 1);
        @(negedge clk);
    endtask

    task automatic final_check(input string tag);
        bit acc;
        cycle_beat(0, 8'h00, 0, acc);
        check({tag, "_done"}, done, m_done);
        check({tag, "_pass"}, pass, m_done && m_err == 0 && m_match != 0);
        check({tag, "_match"}, match_count, 16'(m_match));
        check({tag, "_error"}, error_count, 16'(m_err));
        check({tag, "_eflag"}, err_flag, m_flag);
        check({tag, "_eidx"}, err_index, 16'(m_eidx));
        check({tag, "_edata"}, err_data, 8'(m_edata));
    endtask

    initial begin
        bit acc;
        rst = 1; start = 0; s_valid = 0; s_data = 0; s_last = 0;
        model_reset();
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_ready", s_ready, 0);
        check("rst_match", match_count, 0);
        check("rst_error", error_count, 0);
        check("rst_eflag", err_flag, 0);
        @(negedge clk);
        rst = 0;
        // beats while IDLE are ignored
        cycle_beat(1, 8'd1, 1, acc);
        check("idle_ready", s_ready, 0);
        check("idle_busy", busy, 0);

        // 1: clean run
        do_start();
        check("run_ready", s_ready, 1);
        for (int i = 0; i < 7; i++) send_beat(8'(pow3(i)), i == 6);
        final_check("clean");
        check("done_ready", s_ready, 0);
        cycle_beat(1, 8'd3, 1, acc);
        check("done_hold_match", match_count, 7);

        // 2: single corruption
        do_start();
        send_beat(8'd1, 0); send_beat(8'd3, 0); send_beat(8'd10, 0);
        send_beat(8'd27, 0); send_beat(8'd81, 1);
        final_check("corrupt");
        check("corrupt_eidx_abs", err_index, 2);
        check("corrupt_edata_abs", err_data, 10);

        // 3: gaps, random corruption, s_last without s_valid
        do_start();
        for (int i = 0; i < 20; i++) begin
            int gaps = $urandom_range(0, 2);
            logic [7:0] d = 8'(pow3(i));
            for (int g = 0; g < gaps; g++) cycle_beat(0, 8'hAA, 1, acc);
            if ($urandom_range(0, 4) == 0) d = d ^ 8'h01;
            send_beat(d, i == 19);
        end
        final_check("gaps");

        // 4: start collides with a valid beat
        do_start();
        send_beat(8'd1, 0); send_beat(8'd3, 0);
        start = 1; s_valid = 1; s_data = 8'd9;
        #1;
        check("collision_ready", s_ready, 0);
        @(posedge clk); #1;
        start = 0; s_valid = 0;
        model_reset();
        check("collision_match", match_count, 0);
        check("collision_busy", busy, 1);
        @(negedge clk);
        send_beat(8'd1, 0);
        send_beat(8'd3, 1);
        final_check("collision");

        // 5: asynchronous reset between edges
        do_start();
        for (int i = 0; i < 4; i++) send_beat(8'(pow3(i)), 0);
        #1 rst = 1;
        #1;
        check("arst_match", match_count, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", s_ready, 0);
        #1 rst = 0;
        model_reset();
        @(negedge clk);
        cycle_beat(1, 8'd1, 0, acc);
        check("arst_ignore_ready", s_ready, 0);
        check("arst_ignore_match", match_count, 0);

        // 6: saturation of the 4-bit counter build
        do_start();
        for (int i = 0; i < 20; i++) send_beat(8'(pow3(i)), i == 19);
        final_check("sat");
        check("sat4_match", match_count4, 15);
        check("sat4_error", error_count4, 0);
        check("sat4_pass", pass4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule : tb_power3_checker
`default_nettype wire

// File: doc/power3_checker.md
Name: power3_checker

Overview:
- Stream sink for the power-of-3 generator on the Lab_AXI datapath.
- Accepts beats over a valid/ready handshake and compares each one against an internally computed expected power of 3, truncated modulo 2^data_size.
- Counts matching and mismatching beats, captures the first mismatch, and reports pass/fail once the beat marked last has been accepted.

Parameters:
- data_size, 8, width of the data beat and of the expected value.
- cnt_width, 16, width of the match, error and beat-index counters.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; clears results and arms the checker.
- s_valid  input  1  upstream beat valid.
- s_ready  output  1  checker ready to accept a beat.
- s_data  input  data_size  beat payload.
- s_last  input  1  marks the final beat of a sequence.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.
- pass  output  1  done, error_count==0 and match_count!=0.
- match_count  output  cnt_width  number of beats equal to the expected value.
- error_count  output  cnt_width  number of beats not equal to the expected value.
- err_index  output  cnt_width  beat index (0-based) of the first mismatch.
- err_data  output  data_size  payload of the first mismatch.
- err_flag  output  1  sticky; a mismatch has occurred since the last start.

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high.
- Reset values:
  - state=IDLE, expected=1.
  - All counters, err_index, err_data and err_flag = 0.
  - busy, done and pass = 0.
- States and transitions:
  - IDLE: s_ready=0. start -> RUN.
  - RUN: s_ready=1. An accepted beat with s_last=1 -> DONE. start -> re-arm, stay in RUN.
  - DONE: s_ready=0; results held stable. start -> RUN.
- On start, in any state, the next edge sets:
  - expected=1.
  - match_count, error_count, beat index, err_flag, err_index and err_data = 0.
- s_ready = (state==RUN) && !start, combinational from state and start.
  - A start coinciding with s_valid in RUN does not accept that beat; start wins.
- Beat accepted when s_valid && s_ready. On the same edge:
  - If s_data==expected: match_count increments.
  - Otherwise: error_count increments. If err_flag=0, set err_flag=1 and capture err_index=beat index and err_data=s_data.
  - expected <= (expected*3) mod 2^data_size. Advancing from the internal value prevents one bad beat from cascading into further errors.
  - Beat index increments.
- Counters saturate at all-ones and never wrap. Beat index saturates the same way.
- Results are registered: a beat's outcome is visible the cycle after acceptance, and done rises the cycle after the last beat is accepted.
- Arithmetic wrap-around is expected behaviour. For data_size=8 the sequence is 1, 3, 9, 27, 81, 243, 217, 139, ...
- s_valid while not in RUN: ignored, no state change.
- s_last while s_valid=0: ignored.
- Reset asserted mid-sequence: everything returns to the reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: POWER3_CHK_THROTTLE_EN.
- Defined:
  - A bubble flop forces s_ready=0 for the one cycle following every accepted beat, which exercises upstream backpressure.
  - The bubble flop is cleared by start and by reset.
  - The bubble adds no other latency.
- Undefined: s_ready as specified above; back-to-back beats accepted every cycle.

Decomposition:
- Shared package power3_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - the multiplier constant POW_BASE=3.
  - default widths for data_size and cnt_width.
- One sub-module, power3_expect: holds the expected register, with load-to-1 on start and advance-by-3 on accept, parameterised by data_size.
- FSM, counters and error capture stay in the top module.

Test Plan:
1. Clean run: reset, start, stream 1, 3, 9, 27, 81, 243, 217 with s_last on 217 -> match_count=7, error_count=0, done=1, pass=1, err_flag=0.
2. Single corruption: send 1, 3, 10, 27, 81 with last on 81 -> error_count=1, match_count=4, err_index=2, err_data=10, pass=0; later beats still match.
3. Backpressure and idle gaps: s_valid toggled randomly across 20 beats -> counts equal the number of handshakes. With POWER3_CHK_THROTTLE_EN defined, s_ready is never high on two consecutive cycles after an acceptance.
4. Restart collision: start asserted on the same cycle as s_valid=1 in RUN -> beat not accepted (s_ready=0), counts cleared, expected=1 next cycle.
5. Asynchronous reset mid-stream: rst pulsed between edges after 4 beats -> outputs zero immediately, state IDLE, s_ready=0, beats ignored until the next start.
6. Saturation: cnt_width=4, stream 20 correct beats -> match_count holds at 15, no wrap.
